gcd_job_feeder: RTL
===================

Name: gcd_job_feeder

Overview:
- Upstream feeder and result collector for the GCD core.
- Queues operand pairs arriving on a valid/ready input and issues them one at a time to the core using a one-cycle START pulse.
- Holds the operands stable until the core asserts DONE, then presents Y/ERROR on a valid/ready result port.
- Adds a watchdog so a hung core cannot stall the job stream.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 64, max cycles from START to DONE before the job is aborted (>=2)

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous active-high reset
IN_VALID  input  1  operand pair offered
IN_READY  output  1  feeder can accept a pair
IN_A  input  8  operand A
IN_B  input  8  operand B
GCD_START  output  1  one-cycle start pulse to core
GCD_A  output  8  operand A to core, stable from START until DONE/timeout
GCD_B  output  8  operand B to core, same rule
GCD_DONE  input  1  core completion pulse
GCD_Y  input  8  core result, valid with DONE
GCD_ERROR  input  1  core error flag, valid with DONE
OUT_VALID  output  1  result available
OUT_READY  input  1  consumer takes result
OUT_Y  output  8  result value
OUT_ERROR  output  1  core error or timeout
OUT_TIMEOUT  output  1  job aborted by watchdog
BUSY  output  1  FIFO non-empty or job in flight or result pending

Behaviour:
- Reset (RST high at an edge) clears FIFO pointers and count, state=IDLE, watchdog=0.
  - Outputs after reset: IN_READY=1 (next cycle), GCD_START=0, GCD_A=GCD_B=0, OUT_VALID=0, OUT_Y=0, OUT_ERROR=0, OUT_TIMEOUT=0, BUSY=0.
  - Reset mid-job discards the in-flight job and any queued pairs; no result is produced.
- FIFO:
  - Push on IN_VALID&&IN_READY.
  - IN_READY = (count<DEPTH), registered count only. When full, a same-cycle pop does NOT enable a push.
  - Pointers wrap modulo DEPTH. Pairs are issued in arrival order.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty and OUT_VALID==0, pop the head into the GCD_A/GCD_B registers and go to ISSUE.
  - ISSUE: GCD_START=1 for exactly this cycle; watchdog cleared; go to WAIT.
  - WAIT: watchdog increments each cycle.
    - If GCD_DONE=1: capture OUT_Y=GCD_Y, OUT_ERROR=GCD_ERROR, OUT_TIMEOUT=0; set OUT_VALID; go to IDLE.
    - Else if watchdog==TIMEOUT_CYC-1: OUT_Y=0, OUT_ERROR=1, OUT_TIMEOUT=1; set OUT_VALID; go to IDLE.
    - DONE and timeout in the same cycle: DONE wins.
- GCD_DONE is ignored in IDLE and ISSUE.
- GCD_A/GCD_B change only in IDLE on a pop.
- Output handshake:
  - OUT_VALID stays high with OUT_Y/OUT_ERROR/OUT_TIMEOUT stable until OUT_VALID&&OUT_READY; it clears on the next edge.
  - At most one result is pending; no new START is issued while OUT_VALID=1.
- Minimum latency:
  - Pair pushed at edge k into an idle, empty feeder: pop at k+1, GCD_START high during cycle k+1..k+2.
  - OUT_VALID rises on the edge after the DONE-sampling edge.
- Back-to-back throughput: a new START no earlier than 2 cycles after the previous result is consumed.
- Widths: all data 8-bit unsigned; watchdog width clog2(TIMEOUT_CYC)+1.

Optional Feature:
Macro GCD_FEED_LAT_EN.
- Defined:
  - Adds output OUT_LAT (16-bit): number of cycles from the START cycle to the DONE cycle, inclusive of the DONE cycle.
  - Saturates at 16'hFFFF. Equals TIMEOUT_CYC on timeout.
  - Reset value 0. Valid with OUT_VALID, held stable like OUT_Y.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Push (21,6) with a behavioural GCD core -> exactly one GCD_START pulse, GCD_A=21/GCD_B=6 held until DONE; OUT_VALID with OUT_Y=3, OUT_ERROR=0, OUT_TIMEOUT=0.
- Push (8,17), (35,0), (42,42), (0,0) back-to-back with OUT_READY=1 -> results in order: Y=1; Y=35; Y=42; ERROR=1 with core's Y; four START pulses, never overlapping a pending result.
- Hold OUT_READY=0, push 6 pairs with IN_VALID constant:
  - IN_READY low once count=4.
  - First result held stable; no second START while OUT_VALID=1.
  - Raising OUT_READY drains all jobs in order; total results = accepted pairs.
- Core stub never asserts DONE, TIMEOUT_CYC=64 -> OUT_VALID exactly 64 cycles after the START cycle, OUT_Y=0, OUT_ERROR=1, OUT_TIMEOUT=1; next job then issues normally.
- Assert RST for 1 cycle in WAIT with 2 pairs queued -> next cycle IN_READY=1, BUSY=0, OUT_VALID=0, no START; late DONE from core ignored.
- With GCD_FEED_LAT_EN, core stub asserting DONE 5 cycles after START -> OUT_LAT=6; stub never done, TIMEOUT_CYC=64 -> OUT_LAT=64.

Source files
------------

// File: rtl/gcd_job_feeder.sv
`default_nettype none
// ============================================================================
// Module  : gcd_job_feeder
// Brief   : Operand FIFO feeding a GCD core one job at a time, with a
//           watchdog and a valid/ready result register.
//           Optional macro GCD_FEED_LAT_EN adds the out_lat latency port.
// Rev     : 1.0  initial release
// ============================================================================
module gcd_job_feeder #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        gcd_start,
  output logic [7:0]  gcd_a,
  output logic [7:0]  gcd_b,
  input  logic        gcd_done,
  input  logic [7:0]  gcd_y,
  input  logic        gcd_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_y,
  output logic        out_error,
  output logic        out_timeout,
  output logic        busy
`ifdef GCD_FEED_LAT_EN
  ,
  output logic [15:0] out_lat
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_WD_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [c_PTR_W:0]  c_DEPTH   = (c_PTR_W + 1)'(DEPTH);
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;

  logic [7:0]         r_gcd_a;
  logic [7:0]         r_gcd_b;
  logic [c_WD_W-1:0]  r_wd;
  logic               r_out_valid;
  logic [7:0]         r_out_y;
  logic               r_out_error;
  logic               r_out_timeout;

  logic w_push;
  logic w_pop;
  logic w_start;
  logic w_done_take;
  logic w_timeout_take;

  // Full is judged on the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready = (r_count < c_DEPTH);
  assign w_push   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_start        = 1'b0;
    w_done_take    = 1'b0;
    w_timeout_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_count != '0) && !r_out_valid) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (gcd_done) begin
          w_done_take = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_wd == c_WD_LAST) begin
          w_timeout_take = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog holds the number of cycles elapsed since the START cycle, so the
  // abort lands TIMEOUT_CYC cycles after START.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcd_a       <= '0;
      r_gcd_b       <= '0;
      r_wd          <= '0;
      r_out_valid   <= 1'b0;
      r_out_y       <= '0;
      r_out_error   <= 1'b0;
      r_out_timeout <= 1'b0;
    end else begin
      if (w_pop) begin
        {r_gcd_a, r_gcd_b} <= r_mem[r_rd_ptr];
        r_wd               <= '0;
      end else if (r_state != ST_IDLE) begin
        r_wd <= r_wd + c_WD_W'(1);
      end

      if (w_done_take) begin
        r_out_valid   <= 1'b1;
        r_out_y       <= gcd_y;
        r_out_error   <= gcd_error;
        r_out_timeout <= 1'b0;
      end else if (w_timeout_take) begin
        r_out_valid   <= 1'b1;
        r_out_y       <= '0;
        r_out_error   <= 1'b1;
        r_out_timeout <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef GCD_FEED_LAT_EN
  logic [15:0] r_lat_cnt;
  logic [15:0] r_out_lat;

  // Counts the START cycle as 1, so the value seen in the DONE cycle is the
  // inclusive START..DONE span.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_cnt <= '0;
      r_out_lat <= '0;
    end else begin
      if (w_pop) begin
        r_lat_cnt <= 16'd1;
      end else if ((r_state != ST_IDLE) && (r_lat_cnt != 16'hFFFF)) begin
        r_lat_cnt <= r_lat_cnt + 16'd1;
      end
      if (w_done_take || w_timeout_take) begin
        r_out_lat <= r_lat_cnt;
      end
    end
  end

  assign out_lat = r_out_lat;
`endif

  assign gcd_start   = w_start;
  assign gcd_a       = r_gcd_a;
  assign gcd_b       = r_gcd_b;
  assign out_valid   = r_out_valid;
  assign out_y       = r_out_y;
  assign out_error   = r_out_error;
  assign out_timeout = r_out_timeout;
  assign busy        = (r_count != '0) || (r_state != ST_IDLE) || r_out_valid;

endmodule

`default_nettype wire
